// File: rtl/mcu_seq_pkg.sv
// mcu_seq_pkg: shared definitions for the accumulator-CPU control sequencer.
//   - MCU_* opcode encodings (5-bit), including MCU_HALT
//   - ALU_* operation selector codes (4-bit)
//   - APSR_* bit indices into the program status register
//   - MCU_ST_* sequencer state encodings (3-bit)
//   - exec_t: strobe set produced by the EXECUTE-phase decoder
package mcu_seq_pkg;

  localparam logic [4:0] MCU_NOP    = 5'd0;
  localparam logic [4:0] MCU_LOAD   = 5'd1;
  localparam logic [4:0] MCU_LOADI  = 5'd2;
  localparam logic [4:0] MCU_STORE  = 5'd3;
  localparam logic [4:0] MCU_STOREI = 5'd4;
  localparam logic [4:0] MCU_ADD    = 5'd5;
  localparam logic [4:0] MCU_ADDI   = 5'd6;
  localparam logic [4:0] MCU_SUB    = 5'd7;
  localparam logic [4:0] MCU_SUBI   = 5'd8;
  localparam logic [4:0] MCU_AND    = 5'd9;
  localparam logic [4:0] MCU_ANDI   = 5'd10;
  localparam logic [4:0] MCU_OR     = 5'd11;
  localparam logic [4:0] MCU_ORI    = 5'd12;
  localparam logic [4:0] MCU_XOR    = 5'd13;
  localparam logic [4:0] MCU_XORI   = 5'd14;
  localparam logic [4:0] MCU_NOT    = 5'd15;
  localparam logic [4:0] MCU_SHL    = 5'd16;
  localparam logic [4:0] MCU_SHR    = 5'd17;
  localparam logic [4:0] MCU_JUMP   = 5'd18;
  localparam logic [4:0] MCU_JZ     = 5'd19;
  localparam logic [4:0] MCU_JC     = 5'd20;
  localparam logic [4:0] MCU_JN     = 5'd21;
  localparam logic [4:0] MCU_HALT   = 5'd22;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8,
    ALU_PASS = 4'd9   // operand straight to ACC (LOAD/LOADI)
  } alu_op_e;

  localparam int APSR_ZERO  = 0;
  localparam int APSR_CARRY = 1;
  localparam int APSR_NEG   = 2;
  localparam int APSR_OVF   = 3;

  typedef enum logic [2:0] {
    MCU_ST_RESET   = 3'd0,
    MCU_ST_FETCH   = 3'd1,
    MCU_ST_OPERAND = 3'd2,
    MCU_ST_WAIT    = 3'd3,
    MCU_ST_EXECUTE = 3'd4,
    MCU_ST_HALT    = 3'd5,
    MCU_ST_IRQ     = 3'd6
  } state_e;

  typedef struct packed {
    logic    psr_update;
    logic    acc_update;
    logic    ram_write;
    logic    pc_load;
    logic    halt;
    alu_op_e alu_op;
  } exec_t;

endpackage

// File: rtl/mcu_seq_if.sv
// mcu_seq_if: bundle between the sequencer and the datapath registers.
//   Inputs to sequencer : opcode, psr, stall (+ irq when MCU_IRQ_EN)
//   Outputs of sequencer: psr/opcode/acc/imm update strobes, alu_operation,
//                         pc_count, pc_load, ram_write, halted, state_o
//                         (+ irq_ack when MCU_IRQ_EN)
//   modport master: sequencer side; modport slave: datapath side.
interface mcu_seq_if #(
  parameter int INST_WIDTH  = 5,
  parameter int ALUOP_WIDTH = 4,
  parameter int APSR_WIDTH  = 4
);
  logic [INST_WIDTH-1:0]  opcode;
  logic [APSR_WIDTH-1:0]  psr;
  logic                   stall;
  logic                   psr_update;
  logic                   opcode_update;
  logic                   acc_update;
  logic                   imm_update;
  logic [ALUOP_WIDTH-1:0] alu_operation;
  logic                   pc_count;
  logic                   pc_load;
  logic                   ram_write;
  logic                   halted;
  logic [2:0]             state_o;
`ifdef MCU_IRQ_EN
  logic                   irq;
  logic                   irq_ack;

  modport master (input opcode, psr, stall, irq,
                  output psr_update, opcode_update, acc_update, imm_update, alu_operation,
                         pc_count, pc_load, ram_write, halted, state_o, irq_ack);
  modport slave  (output opcode, psr, stall, irq,
                  input  psr_update, opcode_update, acc_update, imm_update, alu_operation,
                         pc_count, pc_load, ram_write, halted, state_o, irq_ack);
`else
  modport master (input opcode, psr, stall,
                  output psr_update, opcode_update, acc_update, imm_update, alu_operation,
                         pc_count, pc_load, ram_write, halted, state_o);
  modport slave  (output opcode, psr, stall,
                  input  psr_update, opcode_update, acc_update, imm_update, alu_operation,
                         pc_count, pc_load, ram_write, halted, state_o);
`endif
endinterface

// File: rtl/mcu_seq_decode.sv
// mcu_seq_decode: combinational opcode + PSR -> EXECUTE-phase strobe set.
//   i_opcode : current instruction
//   i_psr    : program status register (ZERO/CARRY/NEG used for conditional jumps)
//   o_exec   : psr/acc/ram/pc strobes, halt request and ALU selector
// Register and immediate forms of an ALU op share one ALU code; any
// unlisted opcode decodes to an all-zero strobe set (NOP).
module mcu_seq_decode
  import mcu_seq_pkg::*;
#(
  parameter int INST_WIDTH = 5,
  parameter int APSR_WIDTH = 4
) (
  input  logic [INST_WIDTH-1:0] i_opcode,
  input  logic [APSR_WIDTH-1:0] i_psr,
  output exec_t                 o_exec
);

  always_comb begin
    o_exec = '0;
    case (i_opcode)
      INST_WIDTH'(MCU_LOAD),  INST_WIDTH'(MCU_LOADI):  o_exec.alu_op = ALU_PASS;
      INST_WIDTH'(MCU_STORE), INST_WIDTH'(MCU_STOREI): o_exec.ram_write = 1'b1;
      INST_WIDTH'(MCU_ADD),   INST_WIDTH'(MCU_ADDI):   o_exec.alu_op = ALU_ADD;
      INST_WIDTH'(MCU_SUB),   INST_WIDTH'(MCU_SUBI):   o_exec.alu_op = ALU_SUB;
      INST_WIDTH'(MCU_AND),   INST_WIDTH'(MCU_ANDI):   o_exec.alu_op = ALU_AND;
      INST_WIDTH'(MCU_OR),    INST_WIDTH'(MCU_ORI):    o_exec.alu_op = ALU_OR;
      INST_WIDTH'(MCU_XOR),   INST_WIDTH'(MCU_XORI):   o_exec.alu_op = ALU_XOR;
      INST_WIDTH'(MCU_NOT):  o_exec.alu_op  = ALU_NOT;
      INST_WIDTH'(MCU_SHL):  o_exec.alu_op  = ALU_SHL;
      INST_WIDTH'(MCU_SHR):  o_exec.alu_op  = ALU_SHR;
      INST_WIDTH'(MCU_JUMP): o_exec.pc_load = 1'b1;
      INST_WIDTH'(MCU_JZ):   o_exec.pc_load = i_psr[APSR_ZERO];
      INST_WIDTH'(MCU_JC):   o_exec.pc_load = i_psr[APSR_CARRY];
      INST_WIDTH'(MCU_JN):   o_exec.pc_load = i_psr[APSR_NEG];
      INST_WIDTH'(MCU_HALT): o_exec.halt    = 1'b1;
      default: ;
    endcase
    // Any real ALU op loads ACC and flags; PASS (loads) only loads ACC.
    if (o_exec.alu_op != ALU_NOP) o_exec.acc_update = 1'b1;
    if (o_exec.alu_op != ALU_NOP && o_exec.alu_op != ALU_PASS) o_exec.psr_update = 1'b1;
  end

endmodule

// File: rtl/mcu_seq.sv
// mcu_seq: fetch / operand / wait / execute control sequencer for the
// accumulator CPU.
//   clk, rst : clock; asynchronous active-high reset (state -> RESET)
//   bus      : mcu_seq_if.master -- opcode/psr/stall in, datapath strobes,
//              alu_operation, halted and state_o out
// WAIT_STATES (0..15) inserts RAM-latency cycles between OPERAND and EXECUTE.
// Optional feature macro MCU_IRQ_EN: adds irq/irq_ack and the IRQ state.
// Outputs are pure decodes of state, opcode, psr and stall.
module mcu_seq
  import mcu_seq_pkg::*;
#(
  parameter int INST_WIDTH  = 5,
  parameter int ALUOP_WIDTH = 4,
  parameter int APSR_WIDTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic      clk,
  input  logic      rst,
  mcu_seq_if.master bus
);

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e     r_state, w_next;
  logic [3:0] r_cnt;
  exec_t      w_exec;
  alu_op_e    w_alu;

  mcu_seq_decode #(.INST_WIDTH(INST_WIDTH), .APSR_WIDTH(APSR_WIDTH)) u_dec (
    .i_opcode (bus.opcode),
    .i_psr    (bus.psr),
    .o_exec   (w_exec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MCU_ST_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Counter is zero whenever we are outside WAIT, so it is clear on entry.
      if (r_state != MCU_ST_WAIT) r_cnt <= '0;
      else if (!bus.stall)        r_cnt <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_alu             = ALU_NOP;
    bus.psr_update    = 1'b0;
    bus.opcode_update = 1'b0;
    bus.acc_update    = 1'b0;
    bus.imm_update    = 1'b0;
    bus.pc_count      = 1'b0;
    bus.pc_load       = 1'b0;
    bus.ram_write     = 1'b0;
    bus.halted        = 1'b0;
`ifdef MCU_IRQ_EN
    bus.irq_ack       = 1'b0;
`endif
    case (r_state)
      MCU_ST_RESET: w_next = MCU_ST_FETCH;
      MCU_ST_FETCH: if (!bus.stall) begin
        bus.opcode_update = 1'b1;
        bus.pc_count      = 1'b1;
        w_next            = MCU_ST_OPERAND;
      end
      MCU_ST_OPERAND: if (!bus.stall) begin
        bus.imm_update = 1'b1;
        bus.pc_count   = 1'b1;
        w_next         = (WAIT_STATES > 0) ? MCU_ST_WAIT : MCU_ST_EXECUTE;
      end
      MCU_ST_WAIT: if (!bus.stall && r_cnt == WAIT_LAST) w_next = MCU_ST_EXECUTE;
      MCU_ST_EXECUTE: if (!bus.stall) begin
        bus.psr_update = w_exec.psr_update;
        bus.acc_update = w_exec.acc_update;
        bus.ram_write  = w_exec.ram_write;
        bus.pc_load    = w_exec.pc_load;
        w_alu          = w_exec.alu_op;
        w_next         = w_exec.halt ? MCU_ST_HALT : MCU_ST_FETCH;
`ifdef MCU_IRQ_EN
        // A taken jump owns the PC this cycle; the interrupt waits one instruction.
        if (bus.irq && !w_exec.pc_load) w_next = MCU_ST_IRQ;
`endif
      end
      MCU_ST_HALT: begin
        bus.halted = 1'b1;
`ifdef MCU_IRQ_EN
        if (bus.irq && !bus.stall) w_next = MCU_ST_IRQ;
`endif
      end
`ifdef MCU_IRQ_EN
      MCU_ST_IRQ: if (!bus.stall) begin
        bus.pc_load = 1'b1;
        bus.irq_ack = 1'b1;
        w_next      = MCU_ST_FETCH;
      end
`endif
      default: w_next = MCU_ST_RESET;
    endcase
  end

  assign bus.alu_operation = ALUOP_WIDTH'(w_alu);
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_mcu_seq.sv
// tb_mcu_seq: directed bench for mcu_seq. u0 runs with WAIT_STATES=0,
// u2 with WAIT_STATES=2; both share clk/rst.
// Strobe vector order: {psr,opcode,acc,imm,pc_count,pc_load,ram_write}.
module tb_mcu_seq;
  import mcu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mcu_seq_if #(.INST_WIDTH(5), .ALUOP_WIDTH(4), .APSR_WIDTH(4)) bus0 ();
  mcu_seq_if #(.INST_WIDTH(5), .ALUOP_WIDTH(4), .APSR_WIDTH(4)) bus2 ();

  mcu_seq #(.WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(bus0.master));
  mcu_seq #(.WAIT_STATES(2)) u2 (.clk(clk), .rst(rst), .bus(bus2.master));

  logic [6:0] s0, s2;
  assign s0 = {bus0.psr_update, bus0.opcode_update, bus0.acc_update, bus0.imm_update,
               bus0.pc_count, bus0.pc_load, bus0.ram_write};
  assign s2 = {bus2.psr_update, bus2.opcode_update, bus2.acc_update, bus2.imm_update,
               bus2.pc_count, bus2.pc_load, bus2.ram_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus0.opcode = MCU_ADD; bus0.psr = 4'b0000; bus0.stall = 1'b0;
    bus2.opcode = MCU_ADD; bus2.psr = 4'b0000; bus2.stall = 1'b0;
`ifdef MCU_IRQ_EN
    bus0.irq = 1'b0; bus2.irq = 1'b0;
`endif
    #12;
    chk("reset_state",   32'(bus0.state_o), 32'(MCU_ST_RESET));
    chk("reset_strobes", 32'(s0), 32'h0);
    chk("reset_alu",     32'(bus0.alu_operation), 32'(ALU_NOP));
    chk("reset_halted",  32'(bus0.halted), 32'h0);
    chk("reset_state_w2", 32'(bus2.state_o), 32'(MCU_ST_RESET));
    rst = 1'b0;

    // c1: FETCH
    tick();
    chk("c1_fetch_state", 32'(bus0.state_o), 32'(MCU_ST_FETCH));
    chk("c1_fetch_strb",  32'(s0), 32'b0100100);
    chk("c1_w2_state",    32'(bus2.state_o), 32'(MCU_ST_FETCH));
    // c2: OPERAND
    tick();
    chk("c2_operand_strb", 32'(s0), 32'b0001100);
    chk("c2_w2_state",     32'(bus2.state_o), 32'(MCU_ST_OPERAND));
    // c3: EXECUTE ADD on u0, first WAIT on u2
    tick();
    chk("c3_exec_state", 32'(bus0.state_o), 32'(MCU_ST_EXECUTE));
    chk("c3_add_strb",   32'(s0), 32'b1010000);
    chk("c3_add_alu",    32'(bus0.alu_operation), 32'(ALU_ADD));
    chk("c3_w2_wait",    32'(bus2.state_o), 32'(MCU_ST_WAIT));
    chk("c3_w2_strb",    32'(s2), 32'h0);
    // c4
    tick();
    chk("c4_fetch_state", 32'(bus0.state_o), 32'(MCU_ST_FETCH));
    chk("c4_w2_wait",     32'(bus2.state_o), 32'(MCU_ST_WAIT));
    chk("c4_w2_alu",      32'(bus2.alu_operation), 32'(ALU_NOP));
    // c5: u2 reaches EXECUTE after two wait cycles
    tick();
    chk("c5_operand_state", 32'(bus0.state_o), 32'(MCU_ST_OPERAND));
    chk("c5_w2_exec",       32'(bus2.state_o), 32'(MCU_ST_EXECUTE));
    chk("c5_w2_strb",       32'(s2), 32'b1010000);
    chk("c5_w2_alu",        32'(bus2.alu_operation), 32'(ALU_ADD));
    bus0.opcode = MCU_STORE;
    // c6: EXECUTE STORE, then rst mid-cycle
    tick();
    chk("store_ramw", 32'(s0), 32'b0000001);
    #1 rst = 1'b1;
    #1;
    chk("rst_ramw_drop",  32'(bus0.ram_write), 32'h0);
    chk("rst_state_imm",  32'(bus0.state_o), 32'(MCU_ST_RESET));
    tick();
    chk("rst_hold_state", 32'(bus0.state_o), 32'(MCU_ST_RESET));
    chk("rst_hold_strb",  32'(s0), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_fetch", 32'(bus0.state_o), 32'(MCU_ST_FETCH));
    chk("post_rst_opcupd", 32'(bus0.opcode_update), 32'h1);

    // Conditional jumps and decode variants, all within one EXECUTE cycle
    bus0.opcode = MCU_JZ; bus0.psr = 4'b0001;
    tick();
    tick();
    chk("jz_state",     32'(bus0.state_o), 32'(MCU_ST_EXECUTE));
    chk("jz_taken",     32'(s0), 32'b0000010);
    bus0.psr = 4'b0100; #1;
    chk("jz_neg_only",  32'(bus0.pc_load), 32'h0);
    bus0.opcode = MCU_JN; #1;
    chk("jn_taken",     32'(bus0.pc_load), 32'h1);
    bus0.opcode = MCU_JC; #1;
    chk("jc_not_taken", 32'(bus0.pc_load), 32'h0);
    bus0.psr = 4'b0010; #1;
    chk("jc_taken",     32'(bus0.pc_load), 32'h1);
    bus0.opcode = MCU_LOADI; #1;
    chk("loadi_strb",   32'(s0), 32'b0010000);
    bus0.opcode = MCU_SUBI; #1;
    chk("subi_alu",     32'(bus0.alu_operation), 32'(ALU_SUB));
    bus0.opcode = MCU_STOREI; #1;
    chk("storei_strb",  32'(s0), 32'b0000001);
    bus0.opcode = 5'h1F; #1;
    chk("undef_strb",   32'(s0), 32'h0);
    chk("undef_alu",    32'(bus0.alu_operation), 32'(ALU_NOP));
    bus0.opcode = MCU_ADD; bus0.psr = 4'b0000;
    tick();
    chk("undef_to_fetch", 32'(bus0.state_o), 32'(MCU_ST_FETCH));

    // Stall for three cycles in OPERAND
    tick();
    chk("pre_stall_imm", 32'(bus0.imm_update), 32'h1);
    bus0.stall = 1'b1; #1;
    chk("stall_strb0", 32'(s0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_state", 32'(bus0.state_o), 32'(MCU_ST_OPERAND));
      chk("stall_strb",  32'(s0), 32'h0);
    end
    bus0.stall = 1'b0; #1;
    chk("unstall_imm", 32'(bus0.imm_update), 32'h1);
    tick();
    chk("unstall_exec", 32'(bus0.state_o), 32'(MCU_ST_EXECUTE));
    bus0.opcode = MCU_HALT; #1;
    chk("halt_exec_strb", 32'(s0), 32'h0);

    // HALT holds for 20 cycles, leaves only through rst
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_flag",  32'(bus0.halted), 32'h1);
      chk("halt_strb",  32'(s0), 32'h0);
    end
    chk("halt_state", 32'(bus0.state_o), 32'(MCU_ST_HALT));
    rst = 1'b1; #1;
    chk("halt_rst", 32'(bus0.halted), 32'h0);
    #3 rst = 1'b0;

`ifdef MCU_IRQ_EN
    bus0.opcode = MCU_ADD;
    tick();
    tick();
    tick();
    chk("irq_exec", 32'(bus0.state_o), 32'(MCU_ST_EXECUTE));
    bus0.irq = 1'b1;
    tick();
    bus0.irq = 1'b0;
    chk("irq_state", 32'(bus0.state_o), 32'(MCU_ST_IRQ));
    chk("irq_pcl",   32'(bus0.pc_load), 32'h1);
    chk("irq_ack",   32'(bus0.irq_ack), 32'h1);
    tick();
    chk("irq_fetch", 32'(bus0.state_o), 32'(MCU_ST_FETCH));
    chk("irq_ack0",  32'(bus0.irq_ack), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
